// File: rtl/rv32_mem_pkg.sv
// Shared encodings for the rv32 memory stage; decode/execute use the same width and branch codes.
// Also holds the memory-stage FSM state type and the branch decision helper.
package rv32_mem_pkg;

  localparam logic [1:0] RV32_MEM_WIDTH_BYTE = 2'd0;
  localparam logic [1:0] RV32_MEM_WIDTH_HALF = 2'd1;
  localparam logic [1:0] RV32_MEM_WIDTH_WORD = 2'd2;

  localparam logic [1:0] RV32_BRANCH_OP_NEVER    = 2'd0;
  localparam logic [1:0] RV32_BRANCH_OP_ZERO     = 2'd1;
  localparam logic [1:0] RV32_BRANCH_OP_NON_ZERO = 2'd2;
  localparam logic [1:0] RV32_BRANCH_OP_ALWAYS   = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } mem_state_e;

  function automatic logic branch_eval(input logic [1:0] op, input logic [31:0] value);
    logic taken;
    taken = 1'b0;
    case (op)
      RV32_BRANCH_OP_NEVER:    taken = 1'b0;
      RV32_BRANCH_OP_ZERO:     taken = (value == 32'd0);
      RV32_BRANCH_OP_NON_ZERO: taken = (value != 32'd0);
      RV32_BRANCH_OP_ALWAYS:   taken = 1'b1;
      default:                 taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/rv32_mem_if.sv
// Data bus between the memory stage (master) and the data memory (slave).
// A request is held stable until the slave asserts data_ready_in.
interface rv32_mem_if;
  logic [31:0] data_address_out;
  logic        data_read_out;
  logic        data_write_out;
  logic [3:0]  data_write_mask_out;
  logic [31:0] data_write_value_out;
  logic [31:0] data_read_value_in;
  logic        data_ready_in;

  modport master (
    output data_address_out,
    output data_read_out,
    output data_write_out,
    output data_write_mask_out,
    output data_write_value_out,
    input  data_read_value_in,
    input  data_ready_in
  );

  modport slave (
    input  data_address_out,
    input  data_read_out,
    input  data_write_out,
    input  data_write_mask_out,
    input  data_write_value_out,
    output data_read_value_in,
    output data_ready_in
  );
endinterface

// File: rtl/rv32_mem_align.sv
// Byte-lane handling for the memory stage: store lane replication and masks,
// load extraction with sign/zero extension, and misalignment detection.
module rv32_mem_align
  import rv32_mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  width,
  input  logic        zero_extend,
  input  logic [31:0] store_value,
  input  logic [31:0] read_value,
  output logic        misaligned,
  output logic [3:0]  write_mask,
  output logic [31:0] write_value,
  output logic [31:0] load_value
);

  logic [31:0] shifted;

  // Bring the addressed byte/half down to bit 0 before extension.
  assign shifted = read_value >> {addr_lo, 3'b000};

  always_comb begin
    misaligned  = 1'b0;
    write_mask  = 4'b1111;
    write_value = store_value;
    load_value  = shifted;
    case (width)
      RV32_MEM_WIDTH_BYTE: begin
        write_mask  = 4'b0001 << addr_lo;
        write_value = {4{store_value[7:0]}};
        load_value  = zero_extend ? {24'd0, shifted[7:0]}
                                  : {{24{shifted[7]}}, shifted[7:0]};
      end
      RV32_MEM_WIDTH_HALF: begin
        misaligned  = addr_lo[0];
        write_mask  = addr_lo[1] ? 4'b1100 : 4'b0011;
        write_value = {2{store_value[15:0]}};
        load_value  = zero_extend ? {16'd0, shifted[15:0]}
                                  : {{16{shifted[15]}}, shifted[15:0]};
      end
      RV32_MEM_WIDTH_WORD: begin
        misaligned = |addr_lo;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/rv32_mem.sv
// rv32 memory stage: bus access FSM, pipeline stall generation, branch resolution
// and the output register feeding writeback/forwarding.
module rv32_mem
  import rv32_mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall_in,
  input  logic              flush_in,
  input  logic              mem_read_en_in,
  input  logic              mem_write_en_in,
  input  logic [1:0]        mem_width_in,
  input  logic              mem_zero_extend_in,
  input  logic [1:0]        branch_op_in,
  input  logic [4:0]        rd_in,
  input  logic              rd_writeback_in,
  input  logic [31:0]       result_in,
  input  logic [31:0]       rs2_value_in,
  input  logic [31:0]       branch_pc_in,
  rv32_mem_if.master        bus,
  output logic              stall_out,
  output logic              misaligned_out,
  output logic              branch_taken_out,
  output logic [31:0]       branch_pc_out,
  output logic [4:0]        rd_out,
  output logic              rd_writeback_out,
  output logic [31:0]       rd_value_out
);

  mem_state_e  state;
  logic        flushed_q;
  logic        access;
  logic        misaligned;
  logic [3:0]  write_mask;
  logic [31:0] write_value;
  logic [31:0] load_value;
  logic        rd_update;
  logic        wb_next;
  logic [31:0] value_next;

  rv32_mem_align u_align (
    .addr_lo     (result_in[1:0]),
    .width       (mem_width_in),
    .zero_extend (mem_zero_extend_in),
    .store_value (rs2_value_in),
    .read_value  (bus.data_read_value_in),
    .misaligned  (misaligned),
    .write_mask  (write_mask),
    .write_value (write_value),
    .load_value  (load_value)
  );

  assign access           = mem_read_en_in | mem_write_en_in;
  assign branch_taken_out = branch_eval(branch_op_in, result_in);
  assign branch_pc_out    = branch_pc_in;

  always_comb begin
    stall_out = 1'b0;
    case (state)
      ST_IDLE: stall_out = access & ~misaligned;
      ST_REQ:  stall_out = ~bus.data_ready_in;
      default: stall_out = 1'b0;
    endcase
  end

  assign rd_update = ~stall_in & ~stall_out;

  // A flush seen at any point of an outstanding access is remembered in flushed_q.
  assign wb_next = rd_writeback_in & ~flush_in & ~flushed_q & ~mem_write_en_in
                 & ~(access & misaligned);

  // data_read_out is only ever high in REQ, so it marks the load-completion cycle.
  assign value_next = bus.data_read_out ? load_value : result_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                    <= ST_IDLE;
      flushed_q                <= 1'b0;
      misaligned_out           <= 1'b0;
      bus.data_address_out     <= 32'd0;
      bus.data_read_out        <= 1'b0;
      bus.data_write_out       <= 1'b0;
      bus.data_write_mask_out  <= 4'd0;
      bus.data_write_value_out <= 32'd0;
      rd_out                   <= 5'd0;
      rd_writeback_out         <= 1'b0;
      rd_value_out             <= 32'd0;
    end else begin
      misaligned_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access && !misaligned) begin
            bus.data_address_out     <= {result_in[31:2], 2'b00};
            bus.data_write_out       <= mem_write_en_in;
            bus.data_read_out        <= ~mem_write_en_in;
            bus.data_write_mask_out  <= mem_write_en_in ? write_mask : 4'd0;
            bus.data_write_value_out <= mem_write_en_in ? write_value : 32'd0;
            flushed_q                <= flush_in;
            state                    <= ST_REQ;
          end else if (access && misaligned && !stall_in) begin
            misaligned_out <= 1'b1;
          end
        end
        ST_REQ: begin
          if (flush_in) begin
            flushed_q <= 1'b1;
          end
          if (bus.data_ready_in) begin
            bus.data_read_out  <= 1'b0;
            bus.data_write_out <= 1'b0;
            flushed_q          <= 1'b0;
            state              <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase

      if (rd_update) begin
        rd_out           <= rd_in;
        rd_writeback_out <= wb_next;
        rd_value_out     <= value_next;
      end
    end
  end

endmodule
